gpif_transfer_sched: RTL and testbench
======================================

Name: gpif_transfer_sched

Overview:
Per-frame transfer sequencer in the clk_gpif domain. It consumes the SI payload transfer registers and the stream enable produced by the GPIF register list. For each frame it issues a series of DMA transfer requests to the GPIF write engine: transfer_count full transfers, then final transfer 1, then final transfer 2. It tracks completion and reports end of frame.

Parameters:
REG_WD, 32, width of the size/count register inputs and the beat/index outputs.
BYTE_SHIFT, 2, log2 of bytes per GPIF beat (32-bit bus, so 4 bytes per beat).

Ports:
clk_gpif  in  1  GPIF clock, 100 MHz
reset_gpif  in  1  asynchronous, active-high reset
i_stream_enable_gpif  in  1  stream enable, level
iv_si_payload_transfer_size  in  REG_WD  bytes per full transfer
iv_si_payload_transfer_count  in  REG_WD  number of full transfers per frame
iv_si_payload_final_transfer1_size  in  REG_WD  bytes in final transfer 1
iv_si_payload_final_transfer2_size  in  REG_WD  bytes in final transfer 2
i_frame_start  in  1  single-cycle pulse: frame data is ready in the buffer
o_xfer_req  out  1  transfer request, held high until acknowledged
ov_xfer_beats  out  REG_WD  beats in the requested transfer; stable while o_xfer_req is high
ov_xfer_type  out  2  0 = full, 1 = final1, 2 = final2; stable while o_xfer_req is high
ov_xfer_index  out  REG_WD  index of the full transfer within the frame, 0-based; 0 for finals
i_xfer_ack  in  1  write engine accepts the request
i_xfer_done  in  1  single-cycle pulse: accepted transfer has completed
o_frame_done  out  1  single-cycle pulse: every transfer of the frame has completed
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): state = IDLE. o_xfer_req, o_frame_done, o_busy, ov_xfer_type, ov_xfer_beats and ov_xfer_index all go to 0. Shadow registers clear to 0.
- States: IDLE, LATCH, REQ, WAIT, DONE.
- IDLE -> LATCH when i_frame_start && i_stream_enable_gpif.
  - i_frame_start is ignored in every other state.
  - i_frame_start is ignored in IDLE while the stream is disabled.
- LATCH (one cycle):
  - Copy the four register inputs into shadow registers. Register input changes after this point do not affect the current frame.
  - Convert each size to beats: beats = (size + 2^BYTE_SHIFT - 1) >> BYTE_SHIFT, rounding up. Compute in REG_WD+1 bits so the add cannot overflow.
  - Load remaining_count = count, full_idx = 0, fin1_pend = (final1 beats != 0), fin2_pend = (final2 beats != 0).
  - Run the next-selection rule.
- Next-selection rule, evaluated in LATCH and on i_xfer_done:
  - If remaining_count != 0 and full beats != 0: select full. Set index = full_idx, decrement remaining_count, increment full_idx.
  - Else if fin1_pend: select final1 and clear fin1_pend.
  - Else if fin2_pend: select final2 and clear fin2_pend.
  - Else: go to DONE.
  - Zero-size transfers are skipped. Full beats of 0 skips all full transfers.
  - The selection is registered into ov_xfer_type, ov_xfer_beats and ov_xfer_index at the same edge as the transition to REQ.
- REQ:
  - o_xfer_req = 1.
  - On i_xfer_ack go to WAIT.
  - If i_xfer_ack and i_xfer_done arrive in the same cycle, treat it as completion and run next-selection directly.
  - If i_stream_enable_gpif falls before ack, drop the request and go to IDLE with no o_frame_done.
- WAIT:
  - o_xfer_req = 0.
  - On i_xfer_done, run next-selection.
  - Stream disable during WAIT: the in-flight transfer always completes. At its i_xfer_done go to IDLE with no o_frame_done.
- DONE: o_frame_done = 1 for exactly one cycle, then IDLE.
- Latency:
  - i_frame_start sampled at cycle 0: LATCH at cycle 1, o_xfer_req high at cycle 2.
  - i_xfer_done sampled at cycle t: next o_xfer_req at t+1, or o_frame_done at t+1.
- Degenerate frame (count = 0, or full beats = 0, and both finals = 0): LATCH -> DONE, so o_frame_done at cycle 2 and no request is issued.
- Counters are REG_WD bits wide and do not wrap within a frame, because remaining_count gates issue.
- i_xfer_done outside WAIT, or outside REQ with ack, is ignored.
- i_xfer_ack outside REQ is ignored.

Test Plan:
1. size = 0x100000, count = 4, final1 = 0xCE000, final2 = 0x400; write engine acks in 1 cycle and signals done after 5 cycles -> six requests with (type, beats, index) = (0, 0x40000, 0..3), then (1, 0x33800, 0), then (2, 0x100, 0). o_frame_done pulses once, 1 cycle after the 6th done.
2. Same frame but final1 = 0, final2 = 3 -> four full requests, then one final2 request with beats = 1 (rounded up); no final1 request is issued.
3. count = 0, final1 = 0, final2 = 0 -> frame_start at cycle 0 gives o_frame_done at cycle 2, o_xfer_req never rises, o_busy is high only during cycles 1-2.
4. Change count from 4 to 1 while the 2nd full transfer is in flight -> the frame still issues 4 full transfers. A new frame_start after o_frame_done issues 1 full transfer.
5. Deassert stream enable in REQ (ack withheld) -> o_xfer_req drops next cycle, state returns to IDLE, no o_frame_done. Deassert in WAIT -> no new request after done, no o_frame_done.
6. Assert reset_gpif mid-WAIT -> all outputs 0 immediately, without a clock edge. A frame_start while the stream is disabled, or while busy, is ignored.

Source files
------------

// File: rtl/gpif_transfer_sched.sv
// Per-frame GPIF DMA transfer sequencer: issues the full transfers, then final1 and final2,
// tracks completion and pulses o_frame_done when the whole frame has been written.
module gpif_transfer_sched #(
    parameter int REG_WD     = 32,
    parameter int BYTE_SHIFT = 2
) (
    input  logic              clk_gpif,
    input  logic              reset_gpif,
    input  logic              i_stream_enable_gpif,
    input  logic [REG_WD-1:0] iv_si_payload_transfer_size,
    input  logic [REG_WD-1:0] iv_si_payload_transfer_count,
    input  logic [REG_WD-1:0] iv_si_payload_final_transfer1_size,
    input  logic [REG_WD-1:0] iv_si_payload_final_transfer2_size,
    input  logic              i_frame_start,
    output logic              o_xfer_req,
    output logic [REG_WD-1:0] ov_xfer_beats,
    output logic [1:0]        ov_xfer_type,
    output logic [REG_WD-1:0] ov_xfer_index,
    input  logic              i_xfer_ack,
    input  logic              i_xfer_done,
    output logic              o_frame_done,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] T_FULL = 2'd0;
    localparam logic [1:0] T_FIN1 = 2'd1;
    localparam logic [1:0] T_FIN2 = 2'd2;

    // One bit of headroom keeps the round-up add from overflowing near the top of the range.
    function automatic logic [REG_WD-1:0] to_beats(input logic [REG_WD-1:0] size);
        logic [REG_WD:0] sum;
        sum = {1'b0, size} + (REG_WD+1)'((1 << BYTE_SHIFT) - 1);
        return REG_WD'(sum >> BYTE_SHIFT);
    endfunction

    state_t            state_q, state_d;
    logic [REG_WD-1:0] full_beats_q, full_beats_d;
    logic [REG_WD-1:0] fin1_beats_q, fin1_beats_d;
    logic [REG_WD-1:0] fin2_beats_q, fin2_beats_d;
    logic [REG_WD-1:0] remaining_q, remaining_d;
    logic [REG_WD-1:0] full_idx_q, full_idx_d;
    logic              fin1_pend_q, fin1_pend_d;
    logic              fin2_pend_q, fin2_pend_d;
    logic [1:0]        xfer_type_q, xfer_type_d;
    logic [REG_WD-1:0] xfer_beats_q, xfer_beats_d;
    logic [REG_WD-1:0] xfer_index_q, xfer_index_d;

    logic [REG_WD-1:0] lat_full, lat_fin1, lat_fin2;
    logic [REG_WD-1:0] src_full, src_fin1, src_fin2, src_rem, src_idx;
    logic              src_f1p, src_f2p;
    logic              sel_done, sel_f1p, sel_f2p;
    logic [1:0]        sel_type;
    logic [REG_WD-1:0] sel_beats, sel_idx, sel_rem, sel_next_idx;
    logic              take_sel;

    // Next-selection rule. In LATCH it works on the live register inputs, since the
    // shadow copies are only loaded at the end of that cycle.
    always_comb begin
        lat_full = to_beats(iv_si_payload_transfer_size);
        lat_fin1 = to_beats(iv_si_payload_final_transfer1_size);
        lat_fin2 = to_beats(iv_si_payload_final_transfer2_size);

        if (state_q == S_LATCH) begin
            src_full = lat_full;
            src_fin1 = lat_fin1;
            src_fin2 = lat_fin2;
            src_rem  = iv_si_payload_transfer_count;
            src_idx  = '0;
            src_f1p  = (lat_fin1 != '0);
            src_f2p  = (lat_fin2 != '0);
        end else begin
            src_full = full_beats_q;
            src_fin1 = fin1_beats_q;
            src_fin2 = fin2_beats_q;
            src_rem  = remaining_q;
            src_idx  = full_idx_q;
            src_f1p  = fin1_pend_q;
            src_f2p  = fin2_pend_q;
        end

        sel_done     = 1'b0;
        sel_type     = T_FULL;
        sel_beats    = src_full;
        sel_idx      = src_idx;
        sel_rem      = src_rem;
        sel_next_idx = src_idx;
        sel_f1p      = src_f1p;
        sel_f2p      = src_f2p;

        if (src_rem != '0 && src_full != '0) begin
            sel_rem      = src_rem - 1'b1;
            sel_next_idx = src_idx + 1'b1;
        end else if (src_f1p) begin
            sel_type  = T_FIN1;
            sel_beats = src_fin1;
            sel_idx   = '0;
            sel_f1p   = 1'b0;
        end else if (src_f2p) begin
            sel_type  = T_FIN2;
            sel_beats = src_fin2;
            sel_idx   = '0;
            sel_f2p   = 1'b0;
        end else begin
            sel_done = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
        state_d      = state_q;
        full_beats_d = full_beats_q;
        fin1_beats_d = fin1_beats_q;
        fin2_beats_d = fin2_beats_q;
        remaining_d  = remaining_q;
        full_idx_d   = full_idx_q;
        fin1_pend_d  = fin1_pend_q;
        fin2_pend_d  = fin2_pend_q;
        xfer_type_d  = xfer_type_q;
        xfer_beats_d = xfer_beats_q;
        xfer_index_d = xfer_index_q;
        take_sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_frame_start && i_stream_enable_gpif) state_d = S_LATCH;
            end
            S_LATCH: begin
                full_beats_d = lat_full;
                fin1_beats_d = lat_fin1;
                fin2_beats_d = lat_fin2;
                take_sel     = 1'b1;
            end
            S_REQ: begin
                // An ack with done in the same cycle is a completed transfer.
                if (i_xfer_ack && i_xfer_done) begin
                    if (i_stream_enable_gpif) take_sel = 1'b1;
                    else                      state_d  = S_IDLE;
                end else if (i_xfer_ack) begin
                    state_d = S_WAIT;
                end else if (!i_stream_enable_gpif) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (i_xfer_done) begin
                    if (i_stream_enable_gpif) take_sel = 1'b1;
                    else                      state_d  = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (take_sel) begin
            remaining_d = sel_rem;
            full_idx_d  = sel_next_idx;
            fin1_pend_d = sel_f1p;
            fin2_pend_d = sel_f2p;
            if (sel_done) begin
                state_d = S_DONE;
            end else begin
                state_d      = S_REQ;
                xfer_type_d  = sel_type;
                xfer_beats_d = sel_beats;
                xfer_index_d = sel_idx;
            end
        end
    end

    // NOTE: state is held in flops updated with non-blocking assignments only.
    always_ff @(posedge clk_gpif or posedge reset_gpif) begin
        if (reset_gpif) begin
            state_q      <= S_IDLE;
            full_beats_q <= '0;
            fin1_beats_q <= '0;
            fin2_beats_q <= '0;
            remaining_q  <= '0;
            full_idx_q   <= '0;
            fin1_pend_q  <= 1'b0;
            fin2_pend_q  <= 1'b0;
            xfer_type_q  <= T_FULL;
            xfer_beats_q <= '0;
            xfer_index_q <= '0;
        end else begin
            state_q      <= state_d;
            full_beats_q <= full_beats_d;
            fin1_beats_q <= fin1_beats_d;
            fin2_beats_q <= fin2_beats_d;
            remaining_q  <= remaining_d;
            full_idx_q   <= full_idx_d;
            fin1_pend_q  <= fin1_pend_d;
            fin2_pend_q  <= fin2_pend_d;
            xfer_type_q  <= xfer_type_d;
            xfer_beats_q <= xfer_beats_d;
            xfer_index_q <= xfer_index_d;
        end
    end

    assign o_xfer_req    = (state_q == S_REQ);
    assign o_frame_done  = (state_q == S_DONE);
    assign o_busy        = (state_q != S_IDLE);
    assign ov_xfer_type  = xfer_type_q;
    assign ov_xfer_beats = xfer_beats_q;
    assign ov_xfer_index = xfer_index_q;

endmodule

// File: tb/tb_gpif_transfer_sched.sv
// Randomized self-checking bench for gpif_transfer_sched: a transfer-list model per frame
// plus a randomized write-engine responder, with directed stream-drop and reset scenarios.
module tb_gpif_transfer_sched;

    localparam int W = 32;

    logic         clk_gpif = 1'b0;
    logic         reset_gpif;
    logic         i_stream_enable_gpif;
    logic [W-1:0] iv_size, iv_count, iv_fin1, iv_fin2;
    logic         i_frame_start, i_xfer_ack, i_xfer_done;
    logic         o_xfer_req, o_frame_done, o_busy;
    logic [W-1:0] ov_xfer_beats, ov_xfer_index;
    logic [1:0]   ov_xfer_type;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]   typ;
        logic [W-1:0] beats;
        logic [W-1:0] idx;
    } xfer_t;

    xfer_t exp_q[$];

    always #5 clk_gpif = ~clk_gpif;

    gpif_transfer_sched #(.REG_WD(W), .BYTE_SHIFT(2)) dut (
        .clk_gpif                           (clk_gpif),
        .reset_gpif                         (reset_gpif),
        .i_stream_enable_gpif               (i_stream_enable_gpif),
        .iv_si_payload_transfer_size        (iv_size),
        .iv_si_payload_transfer_count       (iv_count),
        .iv_si_payload_final_transfer1_size (iv_fin1),
        .iv_si_payload_final_transfer2_size (iv_fin2),
        .i_frame_start                      (i_frame_start),
        .o_xfer_req                         (o_xfer_req),
        .ov_xfer_beats                      (ov_xfer_beats),
        .ov_xfer_type                       (ov_xfer_type),
        .ov_xfer_index                      (ov_xfer_index),
        .i_xfer_ack                         (i_xfer_ack),
        .i_xfer_done                        (i_xfer_done),
        .o_frame_done                       (o_frame_done),
        .o_busy                             (o_busy)
    );

    // Reference: the list of transfers a frame should produce, from plain arithmetic.
    function automatic void build_expected(input longint size, input longint count,
                                           input longint f1, input longint f2);
        longint fb, b1, b2;
        xfer_t  x;
        fb = (size + 3) / 4;
        b1 = (f1 + 3) / 4;
        b2 = (f2 + 3) / 4;
        exp_q.delete();
        if (fb != 0) begin
            for (longint i = 0; i < count; i++) begin
                x.typ = 2'd0; x.beats = W'(fb); x.idx = W'(i);
                exp_q.push_back(x);
            end
        end
        if (b1 != 0) begin x.typ = 2'd1; x.beats = W'(b1); x.idx = '0; exp_q.push_back(x); end
        if (b2 != 0) begin x.typ = 2'd2; x.beats = W'(b2); x.idx = '0; exp_q.push_back(x); end
    endfunction

    task automatic set_regs(input logic [W-1:0] s, input logic [W-1:0] c,
                            input logic [W-1:0] f1, input logic [W-1:0] f2);
        iv_size = s; iv_count = c; iv_fin1 = f1; iv_fin2 = f2;
        build_expected(longint'(s), longint'(c), longint'(f1), longint'(f2));
    endtask

    // Runs one frame against exp_q with a randomized write engine. change_at: request number
    // at which iv_count is rewritten; glitch_start pulses i_frame_start while a transfer is in flight.
    task automatic run_frame(input string name, input int change_at, input logic [W-1:0] new_count,
                             input bit fixed_timing, input bit glitch_start);
        int    cyc, phase, ack_wait, done_wait, last_done, n_req;
        bit    prev_done, seen_fd;
        xfer_t e;
        phase = 0; last_done = -10; n_req = 0; prev_done = 0; seen_fd = 0;
        ack_wait = 0; done_wait = 0;
        @(negedge clk_gpif);
        i_frame_start = 1'b1;
        cyc = 0;
        while (cyc < 3000 && !seen_fd) begin
            @(negedge clk_gpif);
            cyc++;
            i_frame_start = 1'b0; i_xfer_ack = 1'b0; i_xfer_done = 1'b0;
            if (cyc == 1) begin
                n_checks++;
                if ({o_busy, o_xfer_req} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL %s latch_cycle: busy/req=%b expected 10", name, {o_busy, o_xfer_req});
                end
            end
            if (o_frame_done) begin
                seen_fd = 1;
                n_checks++;
                if (cyc != ((n_req == 0) ? 2 : last_done + 1) || exp_q.size() != 0 || o_xfer_req) begin
                    n_fail++;
                    $display("FAIL %s frame_done: at cycle %0d (last done %0d), %0d transfers still expected",
                             name, cyc, last_done, exp_q.size());
                end
            end else begin
                if (prev_done && exp_q.size() != 0) begin
                    n_checks++;
                    if (o_xfer_req !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s req_latency: req=%b one cycle after done, expected 1", name, o_xfer_req);
                    end
                end
                if (phase == 0 && o_xfer_req) begin
                    n_req++;
                    if (n_req == 1) begin
                        n_checks++;
                        if (cyc != 2) begin
                            n_fail++;
                            $display("FAIL %s first_req: at cycle %0d expected 2", name, cyc);
                        end
                    end
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_req: type=%0d beats=%h idx=%0d, none expected",
                                 name, ov_xfer_type, ov_xfer_beats, ov_xfer_index);
                    end else begin
                        e = exp_q.pop_front();
                        if ({ov_xfer_type, ov_xfer_beats, ov_xfer_index} !== {e.typ, e.beats, e.idx}) begin
                            n_fail++;
                            $display("FAIL %s req%0d: got type=%0d beats=%h idx=%0d expected type=%0d beats=%h idx=%0d",
                                     name, n_req, ov_xfer_type, ov_xfer_beats, ov_xfer_index, e.typ, e.beats, e.idx);
                        end
                    end
                    if (n_req == change_at) iv_count = new_count;
                    ack_wait = fixed_timing ? 0 : int'($urandom_range(0, 2));
                    phase = 1;
                end
                if (phase == 1) begin
                    if (ack_wait == 0) begin
                        i_xfer_ack = 1'b1;
                        done_wait = fixed_timing ? 5 : int'($urandom_range(0, 4));
                        if (done_wait == 0) begin
                            i_xfer_done = 1'b1;
                            phase = 0;
                        end else begin
                            phase = 2;
                        end
                    end else begin
                        ack_wait--;
                    end
                end else if (phase == 2) begin
                    n_checks++;
                    if (o_xfer_req !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s req_in_wait: req=%b expected 0", name, o_xfer_req);
                    end
                    if (glitch_start) i_frame_start = 1'b1;
                    done_wait--;
                    if (done_wait == 0) begin
                        i_xfer_done = 1'b1;
                        phase = 0;
                    end
                end
            end
            prev_done = i_xfer_done;
            if (i_xfer_done) last_done = cyc;
        end
        i_frame_start = 1'b0; i_xfer_ack = 1'b0; i_xfer_done = 1'b0;
        if (!seen_fd) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no frame_done within cycle budget", name);
        end
        @(negedge clk_gpif);
        n_checks++;
        if ({o_frame_done, o_busy, o_xfer_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s after_frame: done/busy/req=%b expected 000", name, {o_frame_done, o_busy, o_xfer_req});
        end
    endtask

    // Waits (bounded) for a request to appear; returns 0 on timeout after reporting it.
    task automatic wait_req(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk_gpif);
            i_frame_start = 1'b0;
            if (o_xfer_req) ok = 1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL %s wait_req: request never rose", name);
        end
    endtask

    task automatic test_reset();
        reset_gpif = 1'b1;
        repeat (2) @(negedge clk_gpif);
        n_checks++;
        if ({o_xfer_req, o_frame_done, o_busy, ov_xfer_type, ov_xfer_beats, ov_xfer_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b done=%b busy=%b type=%0d beats=%h idx=%h expected all 0",
                     o_xfer_req, o_frame_done, o_busy, ov_xfer_type, ov_xfer_beats, ov_xfer_index);
        end
        reset_gpif = 1'b0;
        @(negedge clk_gpif);
    endtask

    task automatic test_full_frame();
        set_regs(32'h0010_0000, 32'd4, 32'h000C_E000, 32'h0000_0400);
        run_frame("full_frame", 0, '0, 1'b1, 1'b0);
        set_regs(32'h0010_0000, 32'd4, 32'h0, 32'h3);
        run_frame("final2_roundup", 0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_degenerate();
        set_regs(32'h0010_0000, 32'd0, 32'h0, 32'h0);
        run_frame("degenerate_count0", 0, '0, 1'b0, 1'b0);
        set_regs(32'h0, 32'd5, 32'h0, 32'h0);
        run_frame("degenerate_size0", 0, '0, 1'b0, 1'b0);
        set_regs(32'h0, 32'd5, 32'h9, 32'h0);
        run_frame("zero_full_skipped", 0, '0, 1'b0, 1'b0);
        set_regs(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD, 32'h1);
        run_frame("max_size_roundup", 0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_shadow_regs();
        set_regs(32'h0010_0000, 32'd4, 32'h0, 32'h0);
        run_frame("count_change_mid_frame", 2, 32'd1, 1'b0, 1'b0);
        set_regs(32'h0010_0000, 32'd1, 32'h0, 32'h0);
        run_frame("count_one_next_frame", 0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_stream_drop();
        bit ok, bad;
        set_regs(32'h40, 32'd3, 32'h8, 32'h4);
        @(negedge clk_gpif);
        i_frame_start = 1'b1;
        wait_req("drop_in_req", ok);
        i_stream_enable_gpif = 1'b0;
        @(negedge clk_gpif);
        n_checks++;
        if ({o_xfer_req, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_in_req: req/busy=%b expected 00", {o_xfer_req, o_busy});
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk_gpif);
            if (o_frame_done || o_xfer_req) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL drop_in_req_quiet: activity seen after drop, expected none");
        end
        i_stream_enable_gpif = 1'b1;

        @(negedge clk_gpif);
        i_frame_start = 1'b1;
        wait_req("drop_in_wait", ok);
        i_xfer_ack = 1'b1;
        @(negedge clk_gpif);
        i_xfer_ack = 1'b0;
        i_stream_enable_gpif = 1'b0;
        n_checks++;
        if ({o_xfer_req, o_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_in_wait_state: req/busy=%b expected 01", {o_xfer_req, o_busy});
        end
        repeat (3) @(negedge clk_gpif);
        i_xfer_done = 1'b1;
        @(negedge clk_gpif);
        i_xfer_done = 1'b0;
        bad = 0;
        repeat (6) begin
            if (o_frame_done || o_xfer_req || o_busy) bad = 1;
            @(negedge clk_gpif);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL drop_in_wait_idle: request/frame_done/busy seen after final done, expected idle");
        end
        i_stream_enable_gpif = 1'b1;
    endtask

    task automatic test_reset_and_ignored_inputs();
        bit ok, bad;
        set_regs(32'h100, 32'd2, 32'h10, 32'h0);
        @(negedge clk_gpif);
        i_frame_start = 1'b1;
        wait_req("reset_mid_wait", ok);
        i_xfer_ack = 1'b1;
        @(negedge clk_gpif);
        i_xfer_ack = 1'b0;
        #2 reset_gpif = 1'b1;
        #1;
        n_checks++;
        if ({o_xfer_req, o_frame_done, o_busy, ov_xfer_type, ov_xfer_beats, ov_xfer_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: req=%b done=%b busy=%b type=%0d beats=%h idx=%h expected all 0",
                     o_xfer_req, o_frame_done, o_busy, ov_xfer_type, ov_xfer_beats, ov_xfer_index);
        end
        @(negedge clk_gpif);
        reset_gpif = 1'b0;

        i_stream_enable_gpif = 1'b0;
        i_frame_start = 1'b1;
        @(negedge clk_gpif);
        i_frame_start = 1'b0;
        i_xfer_ack = 1'b1;
        i_xfer_done = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk_gpif);
            i_xfer_ack = 1'b0; i_xfer_done = 1'b0;
            if (o_busy) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL start_while_disabled: busy rose, expected idle");
        end
        i_stream_enable_gpif = 1'b1;

        i_xfer_ack = 1'b1;
        i_xfer_done = 1'b1;
        @(negedge clk_gpif);
        i_xfer_ack = 1'b0; i_xfer_done = 1'b0;
        n_checks++;
        if ({o_busy, o_xfer_req, o_frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stray_ack_done_idle: busy/req/done=%b expected 000", {o_busy, o_xfer_req, o_frame_done});
        end

        run_frame("start_while_busy", 0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] v[4];
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 3))
                    0:       v[k] = '0;
                    1:       v[k] = W'($urandom_range(1, 8));
                    2:       v[k] = W'($urandom);
                    default: v[k] = W'($urandom_range(1, 4096));
                endcase
            end
            v[3] = W'($urandom_range(0, 5));
            set_regs(v[0], v[3], v[1], v[2]);
            run_frame($sformatf("random%0d", f), 0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset_gpif = 1'b1;
        i_stream_enable_gpif = 1'b1;
        iv_size = '0; iv_count = '0; iv_fin1 = '0; iv_fin2 = '0;
        i_frame_start = 1'b0; i_xfer_ack = 1'b0; i_xfer_done = 1'b0;
        test_reset();
        test_full_frame();
        test_degenerate();
        test_shadow_regs();
        test_stream_drop();
        test_reset_and_ignored_inputs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
